// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the sequential digit-serial multiplier.
package mul_seq_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int DIGIT_W = 2;
   localparam int PP_W    = 4;

endpackage

// File: rtl/mult2x2_core.sv
// Combinational 2x2 unsigned multiply: the single partial-product engine.
module mult2x2_core
   import mul_seq_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   output logic [PP_W-1:0]    p
);

   assign p = PP_W'(x) * PP_W'(y);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential WxW unsigned multiplier sharing one 2x2 core over (W/2)^2 steps.
// Optional early termination on zero upper multiplicand digits: MUL_SEQ_ZERO_SKIP_EN.
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] out
);

   localparam int unsigned D     = W / 2;
   localparam int unsigned S     = D * D;
   localparam int          KW    = (S > 1) ? $clog2(S) : 1;
   localparam int          ACC_W = 2 * W;

   state_t               state, state_nxt;
   logic [KW-1:0]        k;
   logic [W-1:0]         a_r, b_r;
   logic [ACC_W-1:0]     acc, acc_sum;
   logic [DIGIT_W-1:0]   a_dig, b_dig;
   logic [PP_W-1:0]      pp;
   logic                 last_step, skip;
   int unsigned          i_idx, j_idx;

   mult2x2_core u_core (
      .x (a_dig),
      .y (b_dig),
      .p (pp)
   );

   // Step k walks the a digits slowly (outer) and b digits fast (inner).
   always_comb begin
      i_idx     = 32'(k) / D;
      j_idx     = 32'(k) % D;
      a_dig     = a_r[DIGIT_W*i_idx +: DIGIT_W];
      b_dig     = b_r[DIGIT_W*j_idx +: DIGIT_W];
      acc_sum   = acc + (ACC_W'(pp) << (DIGIT_W * (i_idx + j_idx)));
      last_step = (k == KW'(S - 1));
`ifdef MUL_SEQ_ZERO_SKIP_EN
      skip      = ((a_r >> (DIGIT_W * i_idx)) == '0);
`else
      skip      = 1'b0;
`endif
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (skip || last_step) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         k     <= '0;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         out   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r <= a;
                  b_r <= b;
                  acc <= '0;
                  k   <= '0;
               end
            end
            CALC: begin
               // A skip cycle contributes nothing: the remaining digits are zero.
               if (skip) begin
                  out <= acc;
               end else if (last_step) begin
                  out <= acc_sum;
               end else begin
                  acc <= acc_sum;
                  k   <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl (W=4) against a behavioural model.
module tb_mul_seq_ctrl;

   localparam int W = 4;
   localparam int D = W / 2;
   localparam int S = D * D;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] out;

   int checks = 0;
   int failures = 0;

   mul_seq_ctrl #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   always #5 clk = ~clk;

   // Cycles from the start-sampling edge until done is observed.
   function automatic int model_lat(input logic [W-1:0] av);
`ifdef MUL_SEQ_ZERO_SKIP_EN
      for (int s = 0; s < S; s++) begin
         if ((int'(av) >> (2 * (s / D))) == 0) return s + 2;
      end
`endif
      return S + 1;
   endfunction

   // Launch one operation and observe a fixed window; reports observations only.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output logic [2*W-1:0] res,
                        output int ndone, output int nbusy);
      lat = -1; res = '0; ndone = 0; nbusy = 0;
      @(posedge clk); #1;
      start = 1'b1; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      for (int c = 1; c <= S + 4; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (lat < 0) begin lat = c; res = out; end
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
      checks++; if (out !== '0) begin failures++; $display("FAIL reset_out got=%0d want=0", out); end
      @(posedge clk); #1; rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat, nd, nb; logic [2*W-1:0] r;
      do_op(4'd2, 4'd3, lat, r, nd, nb);
      checks++; if (lat !== model_lat(4'd2)) begin failures++; $display("FAIL basic_lat got=%0d want=%0d", lat, model_lat(4'd2)); end
      checks++; if (r !== 8'd6) begin failures++; $display("FAIL basic_out got=%0d want=6", r); end
      checks++; if (nd !== 1) begin failures++; $display("FAIL basic_ndone got=%0d want=1", nd); end
      checks++; if (nb !== model_lat(4'd2)) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=%0d", nb, model_lat(4'd2)); end
      do_op(4'd15, 4'd15, lat, r, nd, nb);
      checks++; if (r !== 8'd225) begin failures++; $display("FAIL max_out got=%0d want=225", r); end
      checks++; if (lat !== S + 1) begin failures++; $display("FAIL max_lat got=%0d want=%0d", lat, S + 1); end
   endtask

   task automatic test_sweep();
      int lat, nd, nb; logic [2*W-1:0] r; int exp_p;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            do_op(W'(x), W'(y), lat, r, nd, nb);
            exp_p = x * y;
            checks++; if (r !== 8'(exp_p)) begin failures++; $display("FAIL sweep_out a=%0d b=%0d got=%0d want=%0d", x, y, r, exp_p); end
            checks++; if (nd !== 1) begin failures++; $display("FAIL sweep_ndone a=%0d b=%0d got=%0d want=1", x, y, nd); end
            checks++; if (lat !== model_lat(W'(x))) begin failures++; $display("FAIL sweep_lat a=%0d b=%0d got=%0d want=%0d", x, y, lat, model_lat(W'(x))); end
         end
      end
   endtask

   task automatic test_random();
      int lat, nd, nb; logic [2*W-1:0] r; logic [W-1:0] x, y;
      for (int n = 0; n < 20; n++) begin
         x = W'($urandom); y = W'($urandom);
         do_op(x, y, lat, r, nd, nb);
         checks++; if (r !== 8'(int'(x) * int'(y))) begin failures++; $display("FAIL rand_out a=%0d b=%0d got=%0d want=%0d", x, y, r, int'(x) * int'(y)); end
         checks++; if (nb !== lat) begin failures++; $display("FAIL rand_busy a=%0d got=%0d want=%0d", x, nb, lat); end
      end
   endtask

   task automatic test_ignore_start();
      int lat = -1, nd = 0;
      logic [2*W-1:0] r = '0;
      @(posedge clk); #1;
      start = 1'b1; a = 4'd9; b = 4'd7;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= S + 5; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (c == 2 || c == model_lat(4'd9)) begin start = 1'b1; a = 4'd1; b = 4'd1; end
         else start = 1'b0;
         if (done) begin nd++; if (lat < 0) begin lat = c; r = out; end end
      end
      start = 1'b0;
      checks++; if (r !== 8'd63) begin failures++; $display("FAIL ignore_out got=%0d want=63", r); end
      checks++; if (nd !== 1) begin failures++; $display("FAIL ignore_ndone got=%0d want=1", nd); end
      checks++; if (lat !== model_lat(4'd9)) begin failures++; $display("FAIL ignore_lat got=%0d want=%0d", lat, model_lat(4'd9)); end
      repeat (S + 3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int lat, nd, nb; logic [2*W-1:0] r; int nd2 = 0;
      @(posedge clk); #1;
      start = 1'b1; a = 4'd5; b = 4'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b want=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b want=0", done); end
      checks++; if (out !== '0) begin failures++; $display("FAIL midrst_out got=%0d want=0", out); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < S + 3; c++) begin
         @(posedge clk); #1;
         if (done) nd2++;
      end
      checks++; if (nd2 !== 0) begin failures++; $display("FAIL midrst_spurious_done got=%0d want=0", nd2); end
      do_op(4'd3, 4'd2, lat, r, nd, nb);
      checks++; if (r !== 8'd6) begin failures++; $display("FAIL midrst_after_out got=%0d want=6", r); end
   endtask

   task automatic test_back_to_back();
      int dcyc[$]; logic [2*W-1:0] dout[$]; int exp1, exp2, guard;
      @(posedge clk); #1;
      start = 1'b1; a = 4'd1; b = 4'd1;
      @(posedge clk); #1;
      a = 4'd2; b = 4'd2;
      for (int c = 1; c <= 2 * S + 6; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (done) begin dcyc.push_back(c); dout.push_back(out); end
      end
      start = 1'b0;
      exp1 = model_lat(4'd1);
      exp2 = exp1 + 1 + model_lat(4'd2);
      checks++; if (dcyc.size() < 2) begin failures++; $display("FAIL b2b_count got=%0d want>=2", dcyc.size()); end
      else begin
         checks++; if (dcyc[0] !== exp1) begin failures++; $display("FAIL b2b_first_done got=%0d want=%0d", dcyc[0], exp1); end
         checks++; if (dcyc[1] !== exp2) begin failures++; $display("FAIL b2b_second_done got=%0d want=%0d", dcyc[1], exp2); end
         checks++; if (dout[0] !== 8'd1) begin failures++; $display("FAIL b2b_out1 got=%0d want=1", dout[0]); end
         checks++; if (dout[1] !== 8'd4) begin failures++; $display("FAIL b2b_out2 got=%0d want=4", dout[1]); end
      end
      guard = 0;
      while (busy && guard < 4 * S + 10) begin @(posedge clk); #1; guard++; end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain busy=%0b want=0", busy); end
   endtask

   task automatic test_zero_skip();
      int lat, nd, nb; logic [2*W-1:0] r;
      do_op(4'd0, 4'd3, lat, r, nd, nb);
`ifdef MUL_SEQ_ZERO_SKIP_EN
      checks++; if (lat !== 2) begin failures++; $display("FAIL zs_a0_lat got=%0d want=2", lat); end
`else
      checks++; if (lat !== 5) begin failures++; $display("FAIL zs_a0_lat got=%0d want=5", lat); end
`endif
      checks++; if (r !== 8'd0) begin failures++; $display("FAIL zs_a0_out got=%0d want=0", r); end
      do_op(4'd1, 4'd3, lat, r, nd, nb);
`ifdef MUL_SEQ_ZERO_SKIP_EN
      checks++; if (lat !== 4) begin failures++; $display("FAIL zs_a1_lat got=%0d want=4", lat); end
`else
      checks++; if (lat !== 5) begin failures++; $display("FAIL zs_a1_lat got=%0d want=5", lat); end
`endif
      checks++; if (r !== 8'd3) begin failures++; $display("FAIL zs_a1_out got=%0d want=3", r); end
      do_op(4'd12, 4'd3, lat, r, nd, nb);
      checks++; if (lat !== 5) begin failures++; $display("FAIL zs_a12_lat got=%0d want=5", lat); end
      checks++; if (r !== 8'd36) begin failures++; $display("FAIL zs_a12_out got=%0d want=36", r); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_zero_skip();
      test_random();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
